// File: rtl/dispatch_steer.sv
// Dispatch queue: multi-lane in-order enqueue with ROB allocation, in-order
// steering of up to LANES oldest uops onto per-pipe reservation stations.
module dispatch_steer #(
  parameter  int LANES  = 2,
  parameter  int PIPES  = 2,
  parameter  int DEPTH  = 8,
  parameter  int UOP_W  = 64,
  parameter  int ROB_W  = 5,
  localparam int PIPE_W = (PIPES > 1) ? $clog2(PIPES) : 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    flush,
  input  logic [LANES-1:0]        in_valid,
  input  logic [LANES*UOP_W-1:0]  in_uop,
  input  logic [LANES*PIPE_W-1:0] in_pipe,
  output logic                    in_ready,
  input  logic                    rob_ready,
  input  logic [LANES*ROB_W-1:0]  rob_idx,
  output logic [LANES-1:0]        rob_alloc,
  input  logic [PIPES-1:0]        rs_ready,
  output logic [PIPES-1:0]        disp_valid,
  output logic [PIPES*UOP_W-1:0]  disp_uop,
  output logic [PIPES*ROB_W-1:0]  disp_rob_idx,
  output logic [31:0]             stall_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [UOP_W-1:0]  q_uop  [DEPTH];
  logic [PIPE_W-1:0] q_pipe [DEPTH];
  logic [ROB_W-1:0]  q_rob  [DEPTH];

  logic [AW-1:0]    head;
  logic [AW-1:0]    tail;
  logic [CW-1:0]    count;
  logic [31:0]      stall_q;
  logic             can_accept;
  logic [LANES-1:0] enq_mask;
  logic [CW-1:0]    n_enq;
  logic [CW-1:0]    n_deq;

  // Space check uses the registered count only; a same-cycle dequeue gives no credit.
  always_comb begin
    can_accept = (CW'(DEPTH) - count) >= CW'(LANES);
    in_ready   = can_accept & rob_ready & ~flush & ~rst;
  end

  // Only the contiguous valid prefix from lane 0 is accepted, and ROB allocation
  // follows the same mask so every allocated ROB slot has a queued uop.
  always_comb begin
    logic run;
    run      = in_ready;
    enq_mask = '0;
    n_enq    = '0;
    for (int unsigned i = 0; i < LANES; i++) begin
      run         = run & in_valid[i];
      enq_mask[i] = run;
      n_enq       = n_enq + CW'(run);
    end
  end

  assign rob_alloc = enq_mask;

  always_comb begin
    logic [AW-1:0]    idx;
    logic [PIPE_W-1:0] p;
    logic [PIPES-1:0] used;
    logic             go;
    disp_valid   = '0;
    disp_uop     = '0;
    disp_rob_idx = '0;
    n_deq        = '0;
    used         = '0;
    idx          = '0;
    p            = '0;
    go           = ~flush & ~rst;
    for (int unsigned k = 0; k < LANES; k++) begin
      idx = head + AW'(k);
      p   = q_pipe[idx];
      go  = go & (CW'(k) < count) & (32'(p) < 32'(PIPES)) & rs_ready[p] & ~used[p];
      if (go) begin
        used[p]                                 = 1'b1;
        disp_valid[p]                           = 1'b1;
        disp_uop[int'(p)*UOP_W +: UOP_W]        = q_uop[idx];
        disp_rob_idx[int'(p)*ROB_W +: ROB_W]    = q_rob[idx];
        n_deq                                   = n_deq + CW'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head    <= '0;
      tail    <= '0;
      count   <= '0;
      stall_q <= '0;
    end else if (flush) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      tail  <= tail + AW'(n_enq);
      head  <= head + AW'(n_deq);
      count <= count + n_enq - n_deq;
      if (count != '0 && n_deq == '0 && stall_q != '1)
        stall_q <= stall_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    for (int unsigned i = 0; i < LANES; i++) begin
      if (enq_mask[i]) begin
        q_uop[tail + AW'(i)]  <= in_uop[i*UOP_W +: UOP_W];
        q_pipe[tail + AW'(i)] <= in_pipe[i*PIPE_W +: PIPE_W];
        q_rob[tail + AW'(i)]  <= rob_idx[i*ROB_W +: ROB_W];
      end
    end
  end

  assign stall_cnt = stall_q;

endmodule

// File: doc/dispatch_steer.md
DISPATCH_STEER -- requirements
Module: dispatch_steer

Interface
REQ-001 Parameter LANES, default 2, rename/dispatch width, 1..4.
REQ-002 Parameter PIPES, default 2, number of execution pipes, 2..8.
REQ-003 Parameter DEPTH, default 8, dispatch queue entries, power of two, >= 2*LANES.
REQ-004 Parameter UOP_W, default 64, uop payload width.
REQ-005 Parameter ROB_W, default 5, ROB index width; derived PIPE_W = max(1, clog2(PIPES)).
REQ-006 clk  in  1  sole clock; all state updates on rising edge.
REQ-007 rst  in  1  asynchronous, active-high reset.
REQ-008 flush  in  1  synchronous pipeline flush.
REQ-009 in_valid  in  LANES  per-lane rename uop valid; must be a contiguous prefix from lane 0.
REQ-010 in_uop  in  LANES*UOP_W  per-lane uop payload.
REQ-011 in_pipe  in  LANES*PIPE_W  per-lane target pipe id.
REQ-012 in_ready  out  1  all-lane accept; transfer occurs when in_valid!=0 and in_ready=1.
REQ-013 rob_ready  in  1  ROB can allocate LANES entries this cycle.
REQ-014 rob_idx  in  LANES*ROB_W  ROB index assigned to each lane this cycle.
REQ-015 rob_alloc  out  LANES  ROB allocate strobe per lane.
REQ-016 rs_ready  in  PIPES  pipe p reservation station accepts one uop.
REQ-017 disp_valid  out  PIPES  uop presented to pipe p.
REQ-018 disp_uop  out  PIPES*UOP_W  payload to pipe p.
REQ-019 disp_rob_idx  out  PIPES*ROB_W  ROB index to pipe p.
REQ-020 stall_cnt  out  32  saturating dispatch-stall cycle counter.

Function
REQ-021 The queue SHALL be a circular FIFO of DEPTH entries {uop, pipe, rob_idx}, with head, tail (clog2(DEPTH) bits, wrap modulo DEPTH) and count (clog2(DEPTH)+1 bits).
REQ-022 in_ready SHALL be (DEPTH - count >= LANES) & rob_ready & ~flush, computed from the registered count only (no same-cycle dequeue credit).
REQ-023 On transfer, lanes 0..n-1 (n = popcount(in_valid)) SHALL be written at tail..tail+n-1 in lane order, and tail SHALL advance by n.
REQ-024 rob_alloc[i] SHALL equal in_valid[i] & in_ready (combinational), so ROB allocation occurs in program order at enqueue.
REQ-025 Each cycle the block SHALL examine the min(count, LANES) oldest entries, head first.
REQ-026 Examined entry k SHALL dispatch iff every older examined entry dispatches this cycle, rs_ready[pipe_k]=1, and no older entry dispatching this cycle targets pipe_k; the first blocked entry stops dispatch for all younger entries (strict in-order).
REQ-027 For each dispatching entry, disp_valid[pipe]=1 and disp_uop/disp_rob_idx SHALL carry that entry; undriven pipes SHALL have disp_valid=0 and payload zero.
REQ-028 Dispatch outputs SHALL depend only on registered queue state and rs_ready; there is no in_* to disp_* combinational path.
REQ-029 Latency: a uop enqueued at edge N SHALL be dispatchable no earlier than the cycle after edge N.
REQ-030 head SHALL advance by the dispatched count m; count' = count + n - m on simultaneous enqueue and dequeue.
REQ-031 When count=DEPTH (full), in_ready=0; when count=0 (empty), all disp_valid=0.
REQ-032 stall_cnt SHALL increment by 1 in each cycle with count>0, m=0 and ~flush, and SHALL hold at 0xFFFF_FFFF.
REQ-033 flush=1 SHALL force disp_valid=0, rob_alloc=0 and in_ready=0 that cycle, and SHALL set head=tail=count=0 at the edge; stall_cnt is not cleared.
REQ-034 Non-contiguous in_valid is illegal; the block SHALL enqueue only the contiguous prefix from lane 0.

Reset
REQ-035 rst=1 SHALL asynchronously set head=tail=count=0 and stall_cnt=0, and SHALL hold in_ready=0, rob_alloc=0, disp_valid=0 and all payload outputs at 0 while asserted.
REQ-036 Reset asserted mid-operation SHALL discard all queued entries with no partial dispatch at the deassertion edge.

Verification
REQ-037 LANES=2: enqueue A(pipe0), B(pipe1), all rs_ready=1 -> next cycle disp_valid=2'b11, count returns to 0.
REQ-038 Enqueue A(pipe0), B(pipe0) -> cycle 1 dispatches A only; cycle 2 dispatches B; stall_cnt stays 0.
REQ-039 Head entry targets pipe1 with rs_ready[1]=0 for 3 cycles, younger entry targets pipe0 -> no dispatch for 3 cycles, stall_cnt=3, in-order order preserved.
REQ-040 DEPTH=8: 4 enqueues of 2 with rs_ready=0 -> count=8, in_ready=0; release rs_ready -> pointers wrap to 0 correctly.
REQ-041 flush with count=5 and simultaneous in_valid=2'b11 -> rob_alloc=0, next cycle count=0, disp_valid=0.
REQ-042 rst pulse asynchronously between edges with count=6 -> outputs drop immediately; after release count=0 and stall_cnt=0.
